pc_gen: RTL and testbench

//  Parametrised program-counter generator for the fetch stage; successor to the single-source PC.

---
 rtl/cpu_pkg.sv | 14 +
 rtl/pc_target_sel.sv | 50 +++++
 rtl/pc_gen.sv | 144 ++++++++++++++
 tb/tb_pc_gen.sv | 203 ++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared fetch-stage definitions: PC generator states and default address geometry.
package cpu_pkg;

  localparam int unsigned XLEN_DEF   = 32;
  localparam int unsigned IALIGN_DEF = 4;
  localparam logic [XLEN_DEF-1:0] RESET_VEC_DEF = '0;

  typedef enum logic [1:0] {
    BOOT = 2'd0,
    RUN  = 2'd1,
    PEND = 2'd2
  } pc_state_e;

endpackage

// File: rtl/pc_target_sel.sv
// Redirect source selection: fixed-priority mux over trap/JALR/branch targets
// with target arithmetic and the alignment check.
module pc_target_sel
  import cpu_pkg::*;
#(
  parameter int unsigned XLEN   = XLEN_DEF,
  parameter int unsigned IALIGN = IALIGN_DEF
) (
  input  logic            br_taken_i,
  input  logic [XLEN-1:0] br_base_i,
  input  logic [XLEN-1:0] br_imm_i,
  input  logic            jalr_i,
  input  logic [XLEN-1:0] jalr_base_i,
  input  logic [XLEN-1:0] jalr_imm_i,
  input  logic            trap_i,
  input  logic [XLEN-1:0] trap_vec_i,
  output logic            redir_c,
  output logic [XLEN-1:0] tgt_c,
  output logic            misal_c
);

  localparam logic [XLEN-1:0] ALIGN_MASK = XLEN'(IALIGN - 1);

  logic [XLEN-1:0] br_tgt;
  logic [XLEN-1:0] jalr_sum;
  logic [XLEN-1:0] jalr_tgt;

  assign br_tgt   = br_base_i + br_imm_i;
  assign jalr_sum = jalr_base_i + jalr_imm_i;
  assign jalr_tgt = {jalr_sum[XLEN-1:1], 1'b0};

  // Priority: trap > jalr > branch; lower sources are ignored.
  always_comb begin
    redir_c = 1'b0;
    tgt_c   = '0;
    if (trap_i) begin
      redir_c = 1'b1;
      tgt_c   = trap_vec_i;
    end else if (jalr_i) begin
      redir_c = 1'b1;
      tgt_c   = jalr_tgt;
    end else if (br_taken_i) begin
      redir_c = 1'b1;
      tgt_c   = br_tgt;
    end
  end

  assign misal_c = redir_c && ((tgt_c & ALIGN_MASK) != '0);

endmodule

// File: rtl/pc_gen.sv
// Fetch-stage program counter: sequential advance, prioritised redirects,
// imem request handshake with a pending-redirect hold, flush/misalign pulses.
module pc_gen
  import cpu_pkg::*;
#(
  parameter int unsigned     XLEN      = XLEN_DEF,
  parameter logic [XLEN-1:0] RESET_VEC = XLEN'(RESET_VEC_DEF),
  parameter int unsigned     IALIGN    = IALIGN_DEF
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            stall_i,
  input  logic            br_taken_i,
  input  logic [XLEN-1:0] br_base_i,
  input  logic [XLEN-1:0] br_imm_i,
  input  logic            jalr_i,
  input  logic [XLEN-1:0] jalr_base_i,
  input  logic [XLEN-1:0] jalr_imm_i,
  input  logic            trap_i,
  input  logic [XLEN-1:0] trap_vec_i,
  input  logic            fetch_ready_i,
  output logic            fetch_valid_o,
  output logic [XLEN-1:0] fetch_pc_o,
  output logic            flush_o,
  output logic            misalign_o,
  output logic [XLEN-1:0] bad_addr_o
);

  localparam logic [XLEN-1:0] PC_INC = XLEN'(IALIGN);

  pc_state_e       state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic [XLEN-1:0] pend_q, pend_d;
  logic [XLEN-1:0] bad_q, bad_d;
  logic            valid_q, valid_d;
  logic            flush_q, flush_d;
  logic            misal_q, misal_d;

  logic            redir_c;
  logic [XLEN-1:0] tgt_c;
  logic            misal_c;
  logic            take_c;

  pc_target_sel #(
    .XLEN   (XLEN),
    .IALIGN (IALIGN)
  ) u_target_sel (
    .br_taken_i  (br_taken_i),
    .br_base_i   (br_base_i),
    .br_imm_i    (br_imm_i),
    .jalr_i      (jalr_i),
    .jalr_base_i (jalr_base_i),
    .jalr_imm_i  (jalr_imm_i),
    .trap_i      (trap_i),
    .trap_vec_i  (trap_vec_i),
    .redir_c     (redir_c),
    .tgt_c       (tgt_c),
    .misal_c     (misal_c)
  );

  // A misaligned target is reported but never redirects.
  assign take_c = redir_c && !misal_c;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= BOOT;
      pc_q    <= RESET_VEC;
      pend_q  <= '0;
      bad_q   <= '0;
      valid_q <= 1'b0;
      flush_q <= 1'b0;
      misal_q <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      pend_q  <= pend_d;
      bad_q   <= bad_d;
      valid_q <= valid_d;
      flush_q <= flush_d;
      misal_q <= misal_d;
    end
  end

  // Next state, PC and pulse generation; PC only moves when the request is accepted.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    pend_d  = pend_q;
    bad_d   = bad_q;
    flush_d = 1'b0;
    misal_d = 1'b0;

    if (redir_c && misal_c) begin
      misal_d = 1'b1;
      bad_d   = tgt_c;
    end

    unique case (state_q)
      BOOT: begin
        state_d = RUN;
        if (take_c) begin
          pc_d    = tgt_c;
          flush_d = 1'b1;
        end
      end
      RUN: begin
        if (take_c) begin
          flush_d = 1'b1;
          if (fetch_ready_i) begin
            pc_d = tgt_c;
          end else begin
            pend_d  = tgt_c;
            state_d = PEND;
          end
        end else if (!redir_c && fetch_ready_i && !stall_i) begin
          pc_d = pc_q + PC_INC;
        end
      end
      PEND: begin
        if (take_c) begin
          flush_d = 1'b1;
          pend_d  = tgt_c;
          if (fetch_ready_i) begin
            pc_d    = tgt_c;
            state_d = RUN;
          end
        end else if (!redir_c && fetch_ready_i) begin
          pc_d    = pend_q;
          state_d = RUN;
        end
      end
      default: state_d = BOOT;
    endcase

    valid_d = (state_d != BOOT);
  end

  assign fetch_valid_o = valid_q;
  assign fetch_pc_o    = pc_q;
  assign flush_o       = flush_q;
  assign misalign_o    = misal_q;
  assign bad_addr_o    = bad_q;

endmodule

// File: tb/tb_pc_gen.sv
// Directed scoreboard bench for pc_gen (XLEN=32, RESET_VEC=0, IALIGN=4).
module tb_pc_gen;

  typedef struct {
    logic        valid;
    logic [31:0] pc;
    logic        flush;
    logic        misal;
    logic        chk_bad;
    logic [31:0] bad;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        stall_i;
  logic        br_taken_i;
  logic [31:0] br_base_i;
  logic [31:0] br_imm_i;
  logic        jalr_i;
  logic [31:0] jalr_base_i;
  logic [31:0] jalr_imm_i;
  logic        trap_i;
  logic [31:0] trap_vec_i;
  logic        fetch_ready_i;
  logic        fetch_valid_o;
  logic [31:0] fetch_pc_o;
  logic        flush_o;
  logic        misalign_o;
  logic [31:0] bad_addr_o;

  int   n_assert = 0;
  int   n_fail   = 0;
  exp_t exp_q[$];

  always #5 clk = ~clk;

  pc_gen #(
    .XLEN      (32),
    .RESET_VEC (32'h0),
    .IALIGN    (4)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .stall_i       (stall_i),
    .br_taken_i    (br_taken_i),
    .br_base_i     (br_base_i),
    .br_imm_i      (br_imm_i),
    .jalr_i        (jalr_i),
    .jalr_base_i   (jalr_base_i),
    .jalr_imm_i    (jalr_imm_i),
    .trap_i        (trap_i),
    .trap_vec_i    (trap_vec_i),
    .fetch_ready_i (fetch_ready_i),
    .fetch_valid_o (fetch_valid_o),
    .fetch_pc_o    (fetch_pc_o),
    .flush_o       (flush_o),
    .misalign_o    (misalign_o),
    .bad_addr_o    (bad_addr_o)
  );

  task automatic cmp(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic check_out(input string tag);
    exp_t e;
    if (exp_q.size() == 0) begin
      n_assert++;
      n_fail++;
      $error("FAIL %s: scoreboard empty", tag);
    end else begin
      e = exp_q.pop_front();
      cmp({tag, ".valid"}, 32'(fetch_valid_o), 32'(e.valid));
      cmp({tag, ".pc"},    fetch_pc_o,         e.pc);
      cmp({tag, ".flush"}, 32'(flush_o),       32'(e.flush));
      cmp({tag, ".misal"}, 32'(misalign_o),    32'(e.misal));
      if (e.chk_bad) cmp({tag, ".bad"}, bad_addr_o, e.bad);
    end
  endtask

  // Push the expectation for the coming edge, clock once, then compare.
  task automatic step(input string tag, input logic v, input logic [31:0] pc,
                      input logic fl, input logic ms, input logic cb, input logic [31:0] bad);
    exp_t e;
    e.valid = v; e.pc = pc; e.flush = fl; e.misal = ms; e.chk_bad = cb; e.bad = bad;
    exp_q.push_back(e);
    @(posedge clk);
    #1;
    check_out(tag);
  endtask

  task automatic idle();
    br_taken_i = 1'b0; jalr_i = 1'b0; trap_i = 1'b0;
    br_base_i = '0; br_imm_i = '0; jalr_base_i = '0; jalr_imm_i = '0; trap_vec_i = '0;
  endtask

  task automatic br(input logic [31:0] base, input logic [31:0] imm);
    idle();
    br_taken_i = 1'b1; br_base_i = base; br_imm_i = imm;
  endtask

  initial begin
    rst_n = 1'b0; stall_i = 1'b0; fetch_ready_i = 1'b1;
    idle();

    // 1: reset, boot cycle, sequential advance, stall
    step("rst0", 1'b0, 32'h0, 1'b0, 1'b0, 1'b1, 32'h0);
    step("rst1", 1'b0, 32'h0, 1'b0, 1'b0, 1'b1, 32'h0);
    rst_n = 1'b1;
    step("boot", 1'b1, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0);
    step("seq4", 1'b1, 32'h4, 1'b0, 1'b0, 1'b0, 32'h0);
    step("seq8", 1'b1, 32'h8, 1'b0, 1'b0, 1'b0, 32'h0);
    stall_i = 1'b1;
    step("stall_a", 1'b1, 32'h8, 1'b0, 1'b0, 1'b0, 32'h0);
    step("stall_b", 1'b1, 32'h8, 1'b0, 1'b0, 1'b0, 32'h0);

    // 2: taken branch overrides stall
    br(32'h100, 32'h20);
    step("br", 1'b1, 32'h120, 1'b1, 1'b0, 1'b0, 32'h0);
    idle(); stall_i = 1'b0;
    step("br_after", 1'b1, 32'h124, 1'b0, 1'b0, 1'b0, 32'h0);

    // 3: priority, JALR bit-0 clear
    br(32'h100, 32'h20);
    jalr_i = 1'b1; jalr_base_i = 32'h1001; jalr_imm_i = 32'h3;
    trap_i = 1'b1; trap_vec_i = 32'h800;
    step("prio_trap", 1'b1, 32'h800, 1'b1, 1'b0, 1'b0, 32'h0);
    idle();
    jalr_i = 1'b1; jalr_base_i = 32'h1001; jalr_imm_i = 32'h3;
    step("jalr", 1'b1, 32'h1004, 1'b1, 1'b0, 1'b0, 32'h0);
    idle();
    step("jalr_after", 1'b1, 32'h1008, 1'b0, 1'b0, 1'b0, 32'h0);

    // 4: redirect while imem not ready, held then taken; newest wins
    br(32'h40, 32'h0);
    step("to40", 1'b1, 32'h40, 1'b1, 1'b0, 1'b0, 32'h0);
    fetch_ready_i = 1'b0; br(32'h100, 32'h100);
    step("pend_hold", 1'b1, 32'h40, 1'b1, 1'b0, 1'b0, 32'h0);
    idle();
    step("pend_wait", 1'b1, 32'h40, 1'b0, 1'b0, 1'b0, 32'h0);
    fetch_ready_i = 1'b1;
    step("pend_load", 1'b1, 32'h200, 1'b0, 1'b0, 1'b0, 32'h0);
    step("pend_seq", 1'b1, 32'h204, 1'b0, 1'b0, 1'b0, 32'h0);
    fetch_ready_i = 1'b0; br(32'h280, 32'h0);
    step("pend2_a", 1'b1, 32'h204, 1'b1, 1'b0, 1'b0, 32'h0);
    br(32'h300, 32'h0);
    step("pend2_b", 1'b1, 32'h204, 1'b1, 1'b0, 1'b0, 32'h0);
    idle();
    step("pend2_w", 1'b1, 32'h204, 1'b0, 1'b0, 1'b0, 32'h0);
    fetch_ready_i = 1'b1;
    step("pend2_ld", 1'b1, 32'h300, 1'b0, 1'b0, 1'b0, 32'h0);
    fetch_ready_i = 1'b0; br(32'h400, 32'h0);
    step("pend3_a", 1'b1, 32'h300, 1'b1, 1'b0, 1'b0, 32'h0);
    fetch_ready_i = 1'b1; br(32'h500, 32'h0);
    step("pend3_rdy", 1'b1, 32'h500, 1'b1, 1'b0, 1'b0, 32'h0);
    idle();
    step("pend3_seq", 1'b1, 32'h504, 1'b0, 1'b0, 1'b0, 32'h0);
    fetch_ready_i = 1'b0; br(32'h600, 32'h0);
    step("pend4_a", 1'b1, 32'h504, 1'b1, 1'b0, 1'b0, 32'h0);
    idle(); fetch_ready_i = 1'b1; stall_i = 1'b1;
    step("pend4_stall", 1'b1, 32'h600, 1'b0, 1'b0, 1'b0, 32'h0);
    stall_i = 1'b0;

    // 5: misaligned targets
    jalr_i = 1'b1; jalr_base_i = 32'h202; jalr_imm_i = 32'h0;
    step("mis_jalr", 1'b1, 32'h600, 1'b0, 1'b1, 1'b1, 32'h202);
    idle();
    step("mis_after", 1'b1, 32'h604, 1'b0, 1'b0, 1'b0, 32'h0);
    br(32'h100, 32'h2);
    step("mis_br", 1'b1, 32'h604, 1'b0, 1'b1, 1'b1, 32'h102);
    idle();
    step("mis_br_after", 1'b1, 32'h608, 1'b0, 1'b0, 1'b0, 32'h0);

    // 6: wrap, reset in PEND, redirect during BOOT
    trap_i = 1'b1; trap_vec_i = 32'hFFFF_FFFC;
    step("to_top", 1'b1, 32'hFFFF_FFFC, 1'b1, 1'b0, 1'b0, 32'h0);
    idle();
    step("wrap", 1'b1, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0);
    fetch_ready_i = 1'b0; br(32'h700, 32'h0);
    step("pend5", 1'b1, 32'h0, 1'b1, 1'b0, 1'b0, 32'h0);
    idle(); rst_n = 1'b0;
    step("rst_pend", 1'b0, 32'h0, 1'b0, 1'b0, 1'b1, 32'h0);
    rst_n = 1'b1; fetch_ready_i = 1'b1;
    step("boot2", 1'b1, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0);
    step("boot2_seq", 1'b1, 32'h4, 1'b0, 1'b0, 1'b0, 32'h0);
    rst_n = 1'b0;
    step("rst3", 1'b0, 32'h0, 1'b0, 1'b0, 1'b1, 32'h0);
    rst_n = 1'b1; fetch_ready_i = 1'b0; br(32'h900, 32'h0);
    step("boot_redir", 1'b1, 32'h900, 1'b1, 1'b0, 1'b0, 32'h0);
    idle();
    step("boot_hold", 1'b1, 32'h900, 1'b0, 1'b0, 1'b0, 32'h0);
    fetch_ready_i = 1'b1;
    step("boot_seq", 1'b1, 32'h904, 1'b0, 1'b0, 1'b0, 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
